// File: rtl/rgb_pkg.sv
// Shared types for the RGB pixel packer: pixel layout, channel indices and
// packer FSM states.
package rgb_pkg;

  localparam int CHAN_N   = 3;
  localparam int SAMPLE_W = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } pack_state_e;

endpackage

// File: rtl/rgb_pixel_pack_chan_fifo.sv
// chan_fifo: single-channel sample FIFO with (log2(DEPTH)+1)-bit pointers.
// A push while full is accepted only when a pop happens in the same cycle.
// A pop is allowed on an empty FIFO only together with a push; the caller
// then uses the incoming sample directly and the pointers pass each other.
module chan_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      occ
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             wr_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign occ   = wptr - rptr;
  assign dout  = mem[rptr[AW-1:0]];
  assign wr_en = push && (!full || pop);

  // Pointer update; flush empties the FIFO for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= {(AW+1){1'b0}};
      rptr <= {(AW+1){1'b0}};
    end else if (flush) begin
      wptr <= {(AW+1){1'b0}};
      rptr <= {(AW+1){1'b0}};
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
    end
  end

  // Sample storage, cleared on reset so the read port is never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= {WIDTH{1'b0}};
    end else if (wr_en && !flush) begin
      mem[wptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rgb_pixel_pack.sv
// rgb_pixel_pack: buffers independent R/G/B sample streams and emits one
// aligned {R,G,B} pixel whenever all three channels hold a sample. A channel
// whose FIFO is empty but which is pushing this cycle counts as holding a
// sample (bypass), so a completing push shows up on pix one cycle later.
// Optional feature macro: RGB_PACK_CNT_EN adds the accepted-pixel counter
// output pix_cnt.
module rgb_pixel_pack
  import rgb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       R,
  input  logic [7:0]       G,
  input  logic [7:0]       B,
  input  logic [2:0]       valid,
  input  logic [2:0]       done,
  output logic [2:0]       NR,
  output logic [23:0]      pix,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             frame_done,
  output logic [2:0]       ovf_err,
  output logic             mis_err
`ifdef RGB_PACK_CNT_EN
  ,
  output logic [CNT_W-1:0] pix_cnt
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] NR_LIMIT = (AW+1)'(DEPTH - 2);

  pack_state_e state;

  logic [7:0]  din       [CHAN_N];
  logic [7:0]  fifo_dout [CHAN_N];
  logic [7:0]  head      [CHAN_N];
  logic [AW:0] fifo_occ  [CHAN_N];
  logic [AW:0] occ_nxt   [CHAN_N];
  logic [2:0]  fifo_empty;
  logic [2:0]  fifo_full;
  logic [2:0]  avail;
  logic [2:0]  push_ok;
  logic [2:0]  drop;
  logic [2:0]  nr_nxt;
  logic        pop;
  logic        flush;
  logic        drain_end;
  logic        leftover;
  pix_t        head_pix;

  assign din[CH_R] = R;
  assign din[CH_G] = G;
  assign din[CH_B] = B;

  assign flush     = (state == FIN);
  assign pop       = (state != FIN) && (&avail) && (!pix_valid || pix_ready);
  assign drain_end = !(&avail) && !pix_valid;
  assign leftover  = |(~fifo_empty | valid);
  assign head_pix  = '{r: head[CH_R], g: head[CH_G], b: head[CH_B]};

  for (genvar i = 0; i < CHAN_N; i++) begin : g_chan
    assign avail[i]   = !fifo_empty[i] || valid[i];
    assign head[i]    = fifo_empty[i] ? din[i] : fifo_dout[i];
    assign push_ok[i] = valid[i] && (!fifo_full[i] || pop);
    assign drop[i]    = valid[i] && fifo_full[i] && !pop && (state != FIN);
    assign occ_nxt[i] = fifo_occ[i] + {{AW{1'b0}}, push_ok[i]} - {{AW{1'b0}}, pop};
    // One free slot is kept for a sample already in flight.
    assign nr_nxt[i]  = (occ_nxt[i] <= NR_LIMIT);

    chan_fifo #(.DEPTH(DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (valid[i] && (state != FIN)),
      .pop   (pop),
      .din   (din[i]),
      .dout  (fifo_dout[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i]),
      .occ   (fifo_occ[i])
    );
  end

  // Frame FSM with registered request, end-of-frame pulse and mismatch flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      NR         <= 3'b111;
      frame_done <= 1'b0;
      mis_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          NR <= nr_nxt;
          if (|valid) state <= RUN;
        end
        RUN: begin
          if (done == 3'b111) begin
            state <= DRAIN;
            NR    <= 3'b000;
          end else begin
            NR <= nr_nxt;
          end
        end
        DRAIN: begin
          NR <= 3'b000;
          if (drain_end) begin
            state      <= FIN;
            frame_done <= 1'b1;
            if (leftover) mis_err <= 1'b1;
          end
        end
        FIN: begin
          NR    <= 3'b111;
          state <= IDLE;
        end
        default: begin
          NR    <= 3'b111;
          state <= IDLE;
        end
      endcase
    end
  end

  // Output pixel register and its valid/ready handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix       <= 24'h000000;
      pix_valid <= 1'b0;
    end else if (pop) begin
      pix       <= head_pix;
      pix_valid <= 1'b1;
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

  // Sticky per-channel overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 3'b000;
    end else begin
      ovf_err <= ovf_err | drop;
    end
  end

`ifdef RGB_PACK_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Accepted-pixel counter; holds the frame total during FIN, then clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= {CNT_W{1'b0}};
    end else if (state == FIN) begin
      pix_cnt <= {CNT_W{1'b0}};
    end else if (pix_valid && pix_ready) begin
      pix_cnt <= pix_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_pixel_pack.sv
// Directed bench for rgb_pixel_pack (DEPTH=4). Inputs change #1 after the
// rising edge; registered outputs are checked at the same point.
module tb_rgb_pixel_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  R, G, B;
  logic [2:0]  valid, done;
  logic [2:0]  NR;
  logic [23:0] pix;
  logic        pix_valid;
  logic        pix_ready;
  logic        frame_done;
  logic [2:0]  ovf_err;
  logic        mis_err;
`ifdef RGB_PACK_CNT_EN
  logic [15:0] pix_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int acc;
  logic [7:0] er, eg, eb;

  always #5 clk = ~clk;

  rgb_pixel_pack #(.DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .R          (R),
    .G          (G),
    .B          (B),
    .valid      (valid),
    .done       (done),
    .NR         (NR),
    .pix        (pix),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_done (frame_done),
    .ovf_err    (ovf_err),
    .mis_err    (mis_err)
`ifdef RGB_PACK_CNT_EN
    ,
    .pix_cnt    (pix_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; R = 8'h00; G = 8'h00; B = 8'h00;
    valid = 3'b000; done = 3'b000; pix_ready = 1'b0;
    tick; tick;
    chk("rst_nr", NR, 3'b111);
    chk("rst_pix", pix, 24'h000000);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_ovf", ovf_err, 3'b000);
    chk("rst_mis", mis_err, 1'b0);
    rst = 1'b0;
    tick;

    // Balanced triple
    pix_ready = 1'b1;
    R = 8'h10; G = 8'h20; B = 8'h30; valid = 3'b111;
    tick; valid = 3'b000;
    chk("bal_valid", pix_valid, 1'b1);
    chk("bal_pix", pix, 24'h102030);
    chk("bal_nr", NR, 3'b111);
    tick;
    chk("bal_clear", pix_valid, 1'b0);

    // Skewed arrival: R at cycle 0, G at 2, B at 5
    R = 8'h11; valid = 3'b001; tick; valid = 3'b000;
    chk("skew_c0", pix_valid, 1'b0);
    tick;
    G = 8'h22; valid = 3'b010; tick; valid = 3'b000;
    tick; tick;
    chk("skew_c4", pix_valid, 1'b0);
    B = 8'h33; valid = 3'b100; tick; valid = 3'b000;
    chk("skew_valid", pix_valid, 1'b1);
    chk("skew_pix", pix, 24'h112233);
    tick;
    chk("skew_clear", pix_valid, 1'b0);

    // Back-pressure on R only
    pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      R = 8'h41 + 8'(k); valid = 3'b001;
      tick;
      if (k < 2) chk("bp_nr_high", NR[0], 1'b1);
      else       chk("bp_nr_low", NR[0], 1'b0);
      if (k == 3) chk("bp_no_ovf", ovf_err, 3'b000);
      if (k == 4) begin
        chk("bp_ovf", ovf_err, 3'b001);
        chk("bp_pix_hold", pix, 24'h112233);
        chk("bp_pix_valid", pix_valid, 1'b0);
      end
    end
    valid = 3'b000;

    // Drain the held R samples at one pixel per cycle
    pix_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      G = 8'h51 + 8'(k); B = 8'h61 + 8'(k); valid = 3'b110;
      tick;
      er = 8'h41 + 8'(k); eg = 8'h51 + 8'(k); eb = 8'h61 + 8'(k);
      chk("thr_pix", pix, {8'h00, er, eg, eb});
      chk("thr_valid", pix_valid, 1'b1);
    end
    valid = 3'b000;
    tick;
    chk("thr_clear", pix_valid, 1'b0);

    // Mid-frame reset with 2 entries per FIFO and pix_valid high
    pix_ready = 1'b0;
    R = 8'h01; G = 8'h02; B = 8'h03; valid = 3'b111; tick;
    R = 8'h04; G = 8'h05; B = 8'h06; tick;
    R = 8'h07; G = 8'h08; B = 8'h09; tick;
    valid = 3'b000;
    chk("mr_pre_valid", pix_valid, 1'b1);
    chk("mr_pre_pix", pix, 24'h010203);
    #2; rst = 1'b1; #1;
    chk("mr_pix", pix, 24'h000000);
    chk("mr_pix_valid", pix_valid, 1'b0);
    chk("mr_nr", NR, 3'b111);
    chk("mr_ovf", ovf_err, 3'b000);
    chk("mr_fd", frame_done, 1'b0);
    tick; rst = 1'b0;
    tick; tick;
    chk("mr_fd_after", frame_done, 1'b0);
    pix_ready = 1'b1;
    R = 8'h0A; G = 8'h0B; B = 8'h0C; valid = 3'b111; tick; valid = 3'b000;
    chk("mr_fresh_pix", pix, 24'h0A0B0C);
    tick;
    rst = 1'b1; tick; rst = 1'b0; tick;

    // End of frame with 5 complete triples
    acc = 0;
    for (int k = 1; k <= 5; k++) begin
      er = 8'(k); eg = 8'h80 + 8'(k); eb = 8'hC0 + 8'(k);
      R = er; G = eg; B = eb; valid = 3'b111;
      tick;
      chk("eof_pix", pix, {8'h00, er, eg, eb});
      if (pix_valid && pix_ready) acc++;
    end
    valid = 3'b000; done = 3'b111;
    tick;
    chk("eof_fd_early", frame_done, 1'b0);
    tick;
    chk("eof_fd", frame_done, 1'b1);
    chk("eof_nr_fin", NR, 3'b000);
    chk("eof_mis", mis_err, 1'b0);
`ifdef RGB_PACK_CNT_EN
    chk("eof_cnt", pix_cnt, 16'd5);
`endif
    tick;
    chk("eof_fd_once", frame_done, 1'b0);
    chk("eof_nr_idle", NR, 3'b111);
    chk("eof_acc", acc, 5);

    // Count mismatch: 3 R, 2 G, 2 B
    done = 3'b000;
    R = 8'hA1; G = 8'hB1; B = 8'hC1; valid = 3'b111; tick;
    chk("mm_p1", pix, 24'hA1B1C1);
    R = 8'hA2; G = 8'hB2; B = 8'hC2; tick;
    chk("mm_p2", pix, 24'hA2B2C2);
    R = 8'hA3; valid = 3'b001; tick;
    chk("mm_no_pix", pix_valid, 1'b0);
    valid = 3'b000; done = 3'b111;
    tick;
    chk("mm_fd_early", frame_done, 1'b0);
    tick;
    chk("mm_fd", frame_done, 1'b1);
    chk("mm_mis", mis_err, 1'b1);
    tick;
    chk("mm_fd_once", frame_done, 1'b0);
    chk("mm_mis_sticky", mis_err, 1'b1);
    done = 3'b000;
    G = 8'h77; B = 8'h88; valid = 3'b110; tick; valid = 3'b000;
    chk("mm_flushed", pix_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_pixel_pack.md
# rgb_pixel_pack

Downstream consumer of the per-channel run-length decoder. Accepts independent R, G and B sample streams, buffers each stream in a small FIFO, and emits one aligned 24-bit pixel when all three channels hold a sample. Drives the per-channel next-request (`NR`) back-pressure toward the decoder. Signals end of frame once every channel reports done and all buffers have drained.

## Interface
- `DEPTH`, 4, per-channel FIFO entries; power of two, ≥ 2.
- `CNT_W`, 16, pixel counter width (see Configuration).
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `R`, `G`, `B`  in  8 each  channel samples from the decoder.
- `valid`  in  3  per-channel sample strobe; bit 0 = R, bit 1 = G, bit 2 = B.
- `done`  in  3  per-channel level; high = decoder has no further samples this frame.
- `NR`  out  3  per-channel request; high = a sample may be sent next cycle.
- `pix`  out  24  packed pixel `{R,G,B}`.
- `pix_valid`  out  1  `pix` is held stable while this is high and `pix_ready` is low.
- `pix_ready`  in  1  downstream accept.
- `frame_done`  out  1  one-cycle pulse at end of frame.
- `ovf_err`  out  3  sticky per channel: a sample was dropped because its FIFO was full.
- `mis_err`  out  1  sticky: channel sample counts differed at end of frame.

## Operation
- **Push.** When `valid[i]` is high, the sample is written into FIFO *i*.
  - If FIFO *i* is full and no pop occurs that cycle, the sample is dropped and `ovf_err[i]` is set.
  - Full together with a pop in the same cycle: the push is accepted and occupancy is unchanged.
- **Request.** `NR[i]` is registered. It is high when the next-state occupancy of FIFO *i* is ≤ DEPTH−2, leaving one slot for a sample already in flight. It is forced low in states DRAIN and FIN.
- **Pop.** All three FIFOs pop together when all three are non-empty and (`!pix_valid` or `pix_ready`). The popped heads load the `pix` register and `pix_valid` is set.
- **Output handshake.** `pix_valid` clears when `pix_ready` is high and no new pop occurs that cycle.
- **FSM states.**
  - IDLE: waits for any `valid` bit; moves to RUN.
  - RUN: normal push and pop; moves to DRAIN when `done == 3'b111`.
  - DRAIN: continues popping; moves to FIN when no complete triple remains and `pix_valid` is low. If any FIFO is still non-empty at that point, `mis_err` is set and leftover entries are flushed.
  - FIN: pulses `frame_done` for one cycle, resets FIFO pointers, returns to IDLE.
- **Error flags.** `ovf_err` and `mis_err` clear only on `rst`.
- **Pointers.** Each FIFO uses log2(DEPTH)+1-bit pointers. Wrap-around is natural modulo 2·DEPTH. Full = MSBs differ and the remaining bits are equal.

## Timing
- **Reset values.**
  - `NR` = 3'b111.
  - `pix` = 0, `pix_valid` = 0, `frame_done` = 0.
  - `ovf_err` = 0, `mis_err` = 0.
  - FSM in IDLE; FIFOs empty.
- **Latency.**
  - The last channel of a triple pushed in cycle N gives `pix_valid` high in N+1.
  - With `pix_ready` held high, throughput is one pixel per cycle.
- **NR response.** A push that fills FIFO *i* to DEPTH−1 drives `NR[i]` low in the following cycle.
- **End of frame.** `frame_done` is asserted exactly one cycle after the DRAIN→FIN transition condition is met, and lasts one cycle.
- **Reset mid-frame.** Reset takes effect immediately: buffered samples are discarded and no `frame_done` is issued.

## Configuration
- `RGB_PACK_CNT_EN` defined:
  - Adds output `pix_cnt` [CNT_W-1:0], counting accepted pixels (`pix_valid && pix_ready`).
  - The counter wraps at 2^CNT_W.
  - It clears on `rst` and in FIN; the value in FIN reports the full frame count.
- `RGB_PACK_CNT_EN` undefined: the port and counter do not exist; all other behaviour is identical.

## Structure
- **Shared package `rgb_pkg`.**
  - `pix_t` (24-bit packed struct: r, g, b).
  - `chan_e` (CH_R=0, CH_G=1, CH_B=2).
  - FSM state enum `pack_state_e` (IDLE, RUN, DRAIN, FIN).
- **Sub-module `chan_fifo`**, instantiated three times.
  - Parameterised by DEPTH and width 8.
  - Ports: push, pop, data in/out, empty, full, occupancy, flush.
- The FSM, pop logic and output register live in the top.

## Test plan
- **Balanced stream.** Push R=0x10, G=0x20, B=0x30 in the same cycle with `pix_ready`=1 → `pix`=0x102030, `pix_valid` high one cycle later.
- **Skewed arrival.** Push R at cycle 0, G at cycle 2, B at cycle 5 → `pix_valid` first high at cycle 6.
- **Back-pressure.** Hold `pix_ready`=0 with DEPTH=4 and push R every cycle → `NR[0]` low after the third push. A fifth push is dropped, `ovf_err[0]`=1 and `pix` is unchanged.
- **End of frame.** Send 5 complete triples, then `done`=3'b111 → 5 pixels accepted, a one-cycle `frame_done`, `mis_err`=0. With `RGB_PACK_CNT_EN`, `pix_cnt`=5 during FIN.
- **Count mismatch.** Send 3 R, 2 G and 2 B samples, then `done`=3'b111 → 2 pixels emitted, the extra R is flushed, `mis_err`=1, `frame_done` pulses.
- **Mid-frame reset.** Hold 2 entries per FIFO and `pix_valid`=1, then assert `rst` → all outputs return to reset values immediately, with no `frame_done`.
